pueo_fw_bank_ctrl: RTL

//  Sequences the firmware-upgrade byte stream from the command decoder into two ping-pong RAM banks (A/B).
//  One byte arrives per command period; FW mark A/B closes the matching bank and raises a full flag to the CPU GPI.
//  The CPU reads the bank, then acks it; the bank is then free for refill. Supplies the missing backpressure
//  (decoder ignores fw_tready) by detecting and flagging overrun/overflow/sequence errors instead of stalling.

---
 rtl/pueo_fw_bank_pkg.sv | 11 +
 rtl/pueo_fw_bank_ram.sv | 22 ++
 rtl/pueo_fw_bank_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/pueo_fw_bank_pkg.sv
// Shared constants for the firmware-upgrade ping-pong bank controller.
package pueo_fw_bank_pkg;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  localparam int unsigned ERR_OVERRUN  = 0;
  localparam int unsigned ERR_OVERFLOW = 1;
  localparam int unsigned ERR_SEQ      = 2;

endpackage

// File: rtl/pueo_fw_bank_ram.sv
// Simple dual-port byte RAM holding both banks; registered read, no reset so it maps to block RAM.
module pueo_fw_bank_ram #(
  parameter int unsigned AW = 13
) (
  input  logic          sysclk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge sysclk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/pueo_fw_bank_ctrl.sv
// Steers the firmware byte stream into ping-pong banks A/B and flags overrun, overflow and
// mark-sequence errors, since the upstream decoder cannot be stalled.
module pueo_fw_bank_ctrl
  import pueo_fw_bank_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rst_i,
  input  logic [7:0]           fw_tdata_i,
  input  logic                 fw_tvalid_i,
  input  logic [1:0]           fw_mark_i,
  input  logic [1:0]           cpu_ack_i,
  input  logic                 err_clr_i,
  input  logic                 cpu_rd_bank_i,
  input  logic [ADDR_BITS-1:0] cpu_rd_addr_i,
  output logic [7:0]           cpu_rd_data_o,
  output logic [1:0]           bank_full_o,
  output logic [ADDR_BITS:0]   bank_len_a_o,
  output logic [ADDR_BITS:0]   bank_len_b_o,
  output logic                 wr_bank_o,
  output logic [2:0]           err_o
);

  localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic                 tvalid_q;
  logic                 wr_bank_q, wr_bank_d;
  logic [ADDR_BITS:0]   wr_addr_q, wr_addr_d;
  logic [1:0]           full_q, full_d;
  logic [ADDR_BITS:0]   len_a_q, len_a_d;
  logic [ADDR_BITS:0]   len_b_q, len_b_d;
  logic [2:0]           err_q, err_d, err_set;

  logic                 accept, cur_full, at_depth, ram_we;
  logic [1:0]           full_eff;
  logic [ADDR_BITS:0]   addr_after;
  logic                 mark_any, mark_match, mark_take;

  assign accept   = fw_tvalid_i & ~tvalid_q;
  // Acks land before any byte or mark of the same cycle is judged.
  assign full_eff = full_q & ~cpu_ack_i;
  assign cur_full = full_eff[wr_bank_q];
  assign at_depth = (wr_addr_q == DEPTH_CNT);
  assign ram_we   = accept & ~cur_full & ~at_depth & ~sysclk_rst_i;

  assign addr_after = wr_addr_q + {{ADDR_BITS{1'b0}}, ram_we};

  assign mark_any   = |fw_mark_i;
  assign mark_match = (fw_mark_i == ((wr_bank_q == BANK_B) ? 2'b10 : 2'b01));
  assign mark_take  = mark_match & ~cur_full;

  always_comb begin
    full_d    = full_eff;
    len_a_d   = len_a_q;
    len_b_d   = len_b_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = addr_after;
    if (mark_take) begin
      full_d[wr_bank_q] = 1'b1;
      if (wr_bank_q == BANK_A) begin
        len_a_d = addr_after;
      end else begin
        len_b_d = addr_after;
      end
      wr_bank_d = ~wr_bank_q;
      wr_addr_d = '0;
    end

    err_set               = '0;
    err_set[ERR_OVERRUN]  = (accept & cur_full) | (mark_match & cur_full);
    err_set[ERR_OVERFLOW] = accept & ~cur_full & at_depth;
    err_set[ERR_SEQ]      = mark_any & ~mark_match;
    err_d = (err_q & ~{3{err_clr_i}}) | err_set;
  end

  always_ff @(posedge sysclk_i) begin
    // Sampling the live level in reset keeps a valid held through reset from re-firing.
    tvalid_q <= fw_tvalid_i;
    if (sysclk_rst_i) begin
      wr_bank_q <= BANK_A;
      wr_addr_q <= '0;
      full_q    <= '0;
      len_a_q   <= '0;
      len_b_q   <= '0;
      err_q     <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      full_q    <= full_d;
      len_a_q   <= len_a_d;
      len_b_q   <= len_b_d;
      err_q     <= err_d;
    end
  end

  pueo_fw_bank_ram #(
    .AW(ADDR_BITS + 1)
  ) u_ram (
    .sysclk_i(sysclk_i),
    .we_i    (ram_we),
    .waddr_i ({wr_bank_q, wr_addr_q[ADDR_BITS-1:0]}),
    .wdata_i (fw_tdata_i),
    .raddr_i ({cpu_rd_bank_i, cpu_rd_addr_i}),
    .rdata_o (cpu_rd_data_o)
  );

  assign bank_full_o  = full_q;
  assign bank_len_a_o = len_a_q;
  assign bank_len_b_o = len_b_q;
  assign wr_bank_o    = wr_bank_q;
  assign err_o        = err_q;

endmodule
